max_select: RTL and testbench

- Exponent comparator for the FPU add/sub datapath.
- Returns the larger of two biased exponents combinationally, with no latency.
- Also returns which operand won and the absolute exponent difference, which drives mantissa alignment.
- A registered copy of these results, with a valid flag, supports the pipelined FPU stage.

---
 rtl/max_select_pkg.sv | 8 +
 rtl/max_select_exp_compare.sv | 31 +++
 rtl/max_select.sv | 57 +++++
 tb/tb_max_select.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/max_select_pkg.sv
// Shared FPU exponent definitions for the add/sub datapath.
package max_select_pkg;

    localparam int unsigned DEF_EXP_W = 8;

    typedef logic [DEF_EXP_W-1:0] exp_t;

endpackage

// File: rtl/max_select_exp_compare.sv
// Combinational unsigned exponent comparator: larger value, winner flag, magnitude of difference.
module max_select_exp_compare
    import max_select_pkg::*;
#(
    parameter int unsigned EXP_W = DEF_EXP_W
) (
    input  logic [EXP_W-1:0] exp1,
    input  logic [EXP_W-1:0] exp2,
    output logic [EXP_W-1:0] max,
    output logic             sel,
    output logic [EXP_W-1:0] diff,
    output logic             eq
);

    logic b_gt_a;

    assign b_gt_a = (exp2 > exp1);

    always_comb begin
        sel  = b_gt_a;
        eq   = (exp1 == exp2);
        max  = exp1;
        diff = exp1 - exp2;
        // Subtract smaller from larger so the difference never wraps.
        if (b_gt_a) begin
            max  = exp2;
            diff = exp2 - exp1;
        end
    end

endmodule

// File: rtl/max_select.sv
// Exponent max-select with combinational results and a valid-gated registered copy.
module max_select
    import max_select_pkg::*;
#(
    parameter int unsigned EXP_W = DEF_EXP_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [EXP_W-1:0] exp1,
    input  logic [EXP_W-1:0] exp2,
    input  logic             valid_in,
    output logic [EXP_W-1:0] max,
    output logic             sel,
    output logic [EXP_W-1:0] diff,
    output logic             eq,
    output logic [EXP_W-1:0] max_q,
    output logic             sel_q,
    output logic [EXP_W-1:0] diff_q,
    output logic             eq_q,
    output logic             valid_q
);

    max_select_exp_compare #(
        .EXP_W (EXP_W)
    ) u_exp_compare (
        .exp1 (exp1),
        .exp2 (exp2),
        .max  (max),
        .sel  (sel),
        .diff (diff),
        .eq   (eq)
    );

    // Data registers hold their value when valid_in is low; valid_q tracks valid_in every cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            max_q  <= '0;
            sel_q  <= 1'b0;
            diff_q <= '0;
            eq_q   <= 1'b0;
        end else if (valid_in) begin
            max_q  <= max;
            sel_q  <= sel;
            diff_q <= diff;
            eq_q   <= eq;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_in;
        end
    end

endmodule

// File: tb/tb_max_select.sv
// Self-checking bench for max_select: exhaustive combinational sweep plus scoreboarded register stage.
module tb_max_select;
    import max_select_pkg::*;

    localparam int unsigned W = DEF_EXP_W;

    logic   CLK = 1'b0;
    logic   RST;
    exp_t   exp1, exp2;
    logic   valid_in;
    exp_t   max, diff, max_q, diff_q;
    logic   sel, eq, sel_q, eq_q, valid_q;

    int total = 0;
    int bad   = 0;

    // {max, sel, diff, eq} packed result, plus valid for the registered view
    typedef logic [2*W+1:0] res_t;
    res_t         sb_q[$];
    res_t         m_data;
    logic         m_valid;

    max_select #(
        .EXP_W (W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .exp1     (exp1),
        .exp2     (exp2),
        .valid_in (valid_in),
        .max      (max),
        .sel      (sel),
        .diff     (diff),
        .eq       (eq),
        .max_q    (max_q),
        .sel_q    (sel_q),
        .diff_q   (diff_q),
        .eq_q     (eq_q),
        .valid_q  (valid_q)
    );

    always #5 CLK = ~CLK;

    function automatic res_t model(input int a, input int b);
        int mx, df;
        logic s, e;
        if (b > a) begin
            mx = b; s = 1'b1; df = b - a;
        end else begin
            mx = a; s = 1'b0; df = a - b;
        end
        e = (a == b);
        return {mx[W-1:0], s, df[W-1:0], e};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, push the model's registered prediction, compare after the rise.
    task automatic step(input string tag, input int a, input int b, input logic v);
        res_t got;
        logic [2*W+2:0] exp_reg;
        @(negedge CLK);
        exp1     = exp_t'(a);
        exp2     = exp_t'(b);
        valid_in = v;
        if (v) m_data = model(a, b);
        m_valid = v;
        sb_q.push_back(m_data);
        #1;
        check({tag, "_comb"}, 32'({max, sel, diff, eq}), 32'(model(a, b)));
        @(posedge CLK);
        #1;
        got     = sb_q.pop_front();
        exp_reg = {got, m_valid};
        check({tag, "_reg"}, 32'({max_q, sel_q, diff_q, eq_q, valid_q}), 32'(exp_reg));
    endtask

    initial begin
        RST      = 1'b1;
        exp1     = '0;
        exp2     = '0;
        valid_in = 1'b1;
        m_data   = '0;
        m_valid  = 1'b0;
        #1;
        check("reset_state", 32'({max_q, sel_q, diff_q, eq_q, valid_q}), 32'(0));

        // Exhaustive combinational sweep while reset holds the registers at zero
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                exp1 = exp_t'(a);
                exp2 = exp_t'(b);
                #1;
                check("sweep", 32'({max, sel, diff, eq}), 32'(model(a, b)));
            end
        end
        check("reset_hold_sweep", 32'({max_q, sel_q, diff_q, eq_q, valid_q}), 32'(0));

        exp1 = 8'd255; exp2 = 8'd0; #1;
        check("bnd_255_0", 32'({max, sel, diff, eq}), 32'({8'd255, 1'b0, 8'd255, 1'b0}));
        exp1 = 8'd0; exp2 = 8'd255; #1;
        check("bnd_0_255", 32'({max, sel, diff, eq}), 32'({8'd255, 1'b1, 8'd255, 1'b0}));
        exp1 = 8'd128; exp2 = 8'd128; #1;
        check("bnd_tie_128", 32'({max, sel, diff, eq}), 32'({8'd128, 1'b0, 8'd0, 1'b1}));

        valid_in = 1'b0;
        @(negedge CLK);
        RST = 1'b0;

        step("lat_10_200", 10, 200, 1'b1);
        check("lat_max_q", 32'(max_q), 32'(200));
        check("lat_diff_q", 32'(diff_q), 32'(190));
        step("lat_hold", 10, 200, 1'b0);

        step("cap_50_20", 50, 20, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step("hold_3_7", 3, 7, 1'b0);
            check("hold_max_q", 32'(max_q), 32'(50));
            check("hold_diff_q", 32'(diff_q), 32'(30));
            check("hold_max_comb", 32'(max), 32'(7));
        end

        // Asynchronous reset between edges
        step("pre_rst", 10, 200, 1'b1);
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_regs", 32'({max_q, sel_q, diff_q, eq_q, valid_q}), 32'(0));
        check("async_rst_comb", 32'(max), 32'(200));
        valid_in = 1'b1;
        @(posedge CLK);
        #1;
        check("rst_held_edge", 32'({max_q, sel_q, diff_q, eq_q, valid_q}), 32'(0));
        m_data  = '0;
        m_valid = 1'b0;
        @(negedge CLK);
        RST = 1'b0;

        step("b2b_1_2", 1, 2, 1'b1);
        check("b2b_max_q0", 32'(max_q), 32'(2));
        step("b2b_9_4", 9, 4, 1'b1);
        check("b2b_max_q1", 32'(max_q), 32'(9));
        step("b2b_6_6", 6, 6, 1'b1);
        check("b2b_max_q2", 32'(max_q), 32'(6));
        check("b2b_eq_q2", 32'(eq_q), 32'(1));
        step("tail_idle", 0, 255, 1'b0);

        check("sb_empty", 32'(sb_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
